// File: rtl/reloj_pkg.sv
// rtl/reloj_pkg.sv - shared modo encodings for the clock front panel
package reloj_pkg;

    localparam logic [1:0] MODO_HORA = 2'b00;
    localparam logic [1:0] MODO_AJH  = 2'b01;
    localparam logic [1:0] MODO_AJA  = 2'b10;

    // MODE button walks HORA -> AJ_HORA -> AJ_ALARMA -> HORA; 11 folds back to HORA
    function automatic logic [1:0] modo_next(input logic [1:0] m);
        case (m)
            MODO_HORA: modo_next = MODO_AJH;
            MODO_AJH:  modo_next = MODO_AJA;
            default:   modo_next = MODO_HORA;
        endcase
    endfunction

endpackage

// File: rtl/reloj_btn_sync.sv
// rtl/reloj_btn_sync.sv - two-flop button synchronizer with rising-edge press pulse
module reloj_btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic press
);

    logic s1;
    logic s2;
    logic s3;

    // s1/s2 resynchronize the pin, s3 remembers the previous synchronized level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pin;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign press = s2 & ~s3;

endmodule

// File: rtl/reloj_mode_sequencer.sv
// rtl/reloj_mode_sequencer.sv - front-panel mode FSM with auto-repeat and adjust timeout
import reloj_pkg::*;

module reloj_mode_sequencer #(
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100,
    parameter int TIMEOUT_S    = 30
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TICK_MS,
    input  logic       TICK_S,
    input  logic       BTN_MODE,
    input  logic       BTN_SEL,
    input  logic       BTN_INC,
    output logic [1:0] modo,
    output logic       AJH,
    output logic       AJA,
    output logic       AUM,
    output logic       AUH,
    output logic       FIELD
);

    localparam int HW = $clog2(REPEAT_DELAY + 1);
    localparam int TW = $clog2(TIMEOUT_S + 1);

    localparam logic [HW-1:0] HOLD_LAST   = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(REPEAT_DELAY - REPEAT_RATE);
    localparam logic [HW-1:0] HOLD_SAT    = HW'(REPEAT_DELAY);
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_S - 1);
    localparam logic [TW-1:0] TO_SAT      = TW'(TIMEOUT_S);

    logic mode_level, mode_press;
    logic sel_level,  sel_press;
    logic inc_level,  inc_press;

    reloj_btn_sync u_sync_mode (.clk(CLK), .rst(RST), .pin(BTN_MODE), .level(mode_level), .press(mode_press));
    reloj_btn_sync u_sync_sel  (.clk(CLK), .rst(RST), .pin(BTN_SEL),  .level(sel_level),  .press(sel_press));
    reloj_btn_sync u_sync_inc  (.clk(CLK), .rst(RST), .pin(BTN_INC),  .level(inc_level),  .press(inc_press));

    logic [HW-1:0] hold_cnt;
    logic [TW-1:0] to_cnt;

    logic       in_adj;
    logic       hold_hit;
    logic       timeout_hit;
    logic       mode_change;
    logic       sel_take;
    logic       inc_take;
    logic [1:0] modo_nxt;

    // Event arbitration: MODE beats timeout beats SEL beats INC; losers are dropped
    always_comb begin
        in_adj      = (modo != MODO_HORA);
        hold_hit    = in_adj & inc_level & TICK_MS & (hold_cnt == HOLD_LAST);
        timeout_hit = in_adj & ~mode_press & ~inc_level & TICK_S & (to_cnt == TO_LAST);
        mode_change = mode_press | timeout_hit;
        sel_take    = in_adj & ~mode_change & sel_press;
        inc_take    = in_adj & ~mode_change & ~sel_press & (inc_press | hold_hit);
        modo_nxt    = modo;
        if (mode_press) begin
            modo_nxt = modo_next(modo);
        end else if (timeout_hit) begin
            modo_nxt = MODO_HORA;
        end
    end

    // Mode register with registered AJH/AJA decodes
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            modo <= MODO_HORA;
            AJH  <= 1'b0;
            AJA  <= 1'b0;
        end else begin
            modo <= modo_nxt;
            AJH  <= (modo_nxt == MODO_AJH);
            AJA  <= (modo_nxt == MODO_AJA);
        end
    end

    // Field select: toggled by SEL in adjust modes, cleared on any mode change
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            FIELD <= 1'b0;
        end else if (mode_change) begin
            FIELD <= 1'b0;
        end else if (sel_take) begin
            FIELD <= ~FIELD;
        end
    end

    // Increment strobes steered by the current field; mutually exclusive by construction
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            AUM <= 1'b0;
            AUH <= 1'b0;
        end else begin
            AUM <= inc_take & ~FIELD;
            AUH <= inc_take & FIELD;
        end
    end

    // Hold counter: after the first repeat it reloads so the next hit lands REPEAT_RATE ticks later
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold_cnt <= '0;
        end else if (mode_change || !in_adj || !inc_level) begin
            hold_cnt <= '0;
        end else if (TICK_MS) begin
            if (hold_cnt == HOLD_LAST) begin
                hold_cnt <= HOLD_RELOAD;
            end else if (hold_cnt != HOLD_SAT) begin
                hold_cnt <= hold_cnt + HW'(1);
            end
        end
    end

    // Inactivity counter: any press or a held INC keeps the adjust mode alive
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            to_cnt <= '0;
        end else if (mode_change || !in_adj || mode_press || sel_press || inc_press || inc_level) begin
            to_cnt <= '0;
        end else if (TICK_S && (to_cnt != TO_SAT)) begin
            to_cnt <= to_cnt + TW'(1);
        end
    end

endmodule

// File: tb/tb_reloj_mode_sequencer.sv
// tb/tb_reloj_mode_sequencer.sv - randomized and directed bench with a behavioural reference model
module tb_reloj_mode_sequencer;

    localparam int RD = 500;
    localparam int RR = 100;
    localparam int TO = 30;

    logic       clk;
    logic       rst;
    logic       tick_ms;
    logic       tick_s;
    logic       p_mode;
    logic       p_sel;
    logic       p_inc;
    logic [1:0] modo;
    logic       ajh;
    logic       aja;
    logic       aum;
    logic       auh;
    logic       field;

    int n_checks;
    int n_errors;
    int cnt_aum;
    int cnt_auh;

    // reference model state
    int       m_mode;
    int       m_field;
    int       m_held;
    int       m_idle;
    int       e_aum;
    int       e_auh;
    logic [2:0] hm;
    logic [2:0] hs;
    logic [2:0] hi;

    reloj_mode_sequencer #(.REPEAT_DELAY(RD), .REPEAT_RATE(RR), .TIMEOUT_S(TO)) dut (
        .CLK(clk), .RST(rst), .TICK_MS(tick_ms), .TICK_S(tick_s),
        .BTN_MODE(p_mode), .BTN_SEL(p_sel), .BTN_INC(p_inc),
        .modo(modo), .AJH(ajh), .AJA(aja), .AUM(aum), .AUH(auh), .FIELD(field)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_field = 0; m_held = 0; m_idle = 0;
        e_aum = 0; e_auh = 0;
        hm = '0; hs = '0; hi = '0;
    endtask

    // Buttons are seen two edges late; a press is the first cycle the delayed level is high
    task automatic model_edge(input logic tm, input logic ts);
        logic mode_ev, sel_ev, inc_ev, inc_lvl, rep;
        mode_ev = hm[1] & ~hm[2];
        sel_ev  = hs[1] & ~hs[2];
        inc_ev  = hi[1] & ~hi[2];
        inc_lvl = hi[1];
        e_aum = 0;
        e_auh = 0;
        if (mode_ev) begin
            m_mode = (m_mode + 1) % 3;
            m_field = 0; m_held = 0; m_idle = 0;
        end else if (m_mode != 0) begin
            if (ts && !inc_lvl && (m_idle + 1 == TO)) begin
                m_mode = 0; m_field = 0; m_held = 0; m_idle = 0;
            end else begin
                rep = 1'b0;
                if (inc_lvl) begin
                    if (tm) begin
                        m_held++;
                        rep = (m_held >= RD) && ((m_held - RD) % RR == 0);
                    end
                end else begin
                    m_held = 0;
                end
                if (sel_ev || inc_lvl) m_idle = 0;
                else if (ts) m_idle++;
                if (sel_ev) m_field = 1 - m_field;
                else if (inc_ev || rep) begin
                    if (m_field == 1) e_auh = 1;
                    else e_aum = 1;
                end
            end
        end else begin
            m_held = 0;
            m_idle = 0;
        end
        hm = {hm[1:0], p_mode};
        hs = {hs[1:0], p_sel};
        hi = {hi[1:0], p_inc};
    endtask

    task automatic step(input logic tm, input logic ts);
        @(negedge clk);
        tick_ms = tm;
        tick_s  = ts;
        @(posedge clk);
        model_edge(tm, ts);
        #1;
        check("modo",  int'(modo),  m_mode);
        check("ajh",   int'(ajh),   int'(m_mode == 1));
        check("aja",   int'(aja),   int'(m_mode == 2));
        check("aum",   int'(aum),   e_aum);
        check("auh",   int'(auh),   e_auh);
        check("field", int'(field), m_field);
        if (aum) cnt_aum++;
        if (auh) cnt_auh++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0);
    endtask

    // 0 = MODE, 1 = SEL, 2 = INC
    task automatic press(input int b);
        if (b == 0) p_mode = 1'b1;
        else if (b == 1) p_sel = 1'b1;
        else p_inc = 1'b1;
        idle(3);
        if (b == 0) p_mode = 1'b0;
        else if (b == 1) p_sel = 1'b0;
        else p_inc = 1'b0;
        idle(3);
    endtask

    // Mid-cycle asynchronous reset pulse, outputs checked while it is asserted
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check({tag, "_modo"},  int'(modo),  0);
        check({tag, "_aum"},   int'(aum),   0);
        check({tag, "_auh"},   int'(auh),   0);
        check({tag, "_field"}, int'(field), 0);
        check({tag, "_ajh"},   int'(ajh),   0);
        check({tag, "_aja"},   int'(aja),   0);
        model_reset();
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_errors = 0; cnt_aum = 0; cnt_auh = 0;
        tick_ms = 1'b0; tick_s = 1'b0;
        p_mode = 1'b0; p_sel = 1'b0; p_inc = 1'b0;
        rst = 1'b1;
        model_reset();
        #2;
        check("rst_modo",  int'(modo),  0);
        check("rst_strobe", int'(aum) + int'(auh), 0);
        check("rst_field", int'(field), 0);
        check("rst_ajh",   int'(ajh),   0);
        rst = 1'b0;
        idle(3);

        // three MODE presses walk 01, 10, 00
        press(0); check("walk_1", int'(modo), 1); check("walk_1_ajh", int'(ajh), 1);
        press(0); check("walk_2", int'(modo), 2); check("walk_2_aja", int'(aja), 1);
        press(0); check("walk_3", int'(modo), 0); check("walk_3_aj", int'(ajh) + int'(aja), 0);

        // AJ_HORA, INC held with TICK_MS every cycle: press strobe plus repeats at 500, 600, 700
        press(0);
        cnt_aum = 0; cnt_auh = 0;
        p_inc = 1'b1;
        for (int k = 0; k < 760; k++) step(1'b1, 1'b0);
        p_inc = 1'b0;
        idle(5);
        check("hold_aum_count", cnt_aum, 4);
        check("hold_auh_count", cnt_auh, 0);

        // AJ_ALARMA, SEL then INC: one AUH strobe
        press(0);
        press(1);
        check("sel_field", int'(field), 1);
        cnt_aum = 0; cnt_auh = 0;
        press(2);
        check("sel_auh_count", cnt_auh, 1);
        check("sel_aum_count", cnt_aum, 0);

        // reset mid AJ_ALARMA with INC held
        p_inc = 1'b1;
        idle(4);
        async_reset("rst_mid");
        idle(2);
        p_inc = 1'b0;
        idle(3);

        // timeout: 29 ticks, a press restarts, 29 more stay, the 30th returns to HORA
        press(0);
        for (int k = 0; k < TO - 1; k++) begin step(1'b0, 1'b1); idle(3); end
        press(1);
        for (int k = 0; k < TO - 1; k++) begin step(1'b0, 1'b1); idle(3); end
        check("timeout_hold", int'(modo), 1);
        step(1'b0, 1'b1);
        check("timeout_fire", int'(modo), 0);
        check("timeout_field", int'(field), 0);
        idle(3);

        // MODE and INC together in AJ_HORA: MODE wins, no strobe
        press(0);
        cnt_aum = 0; cnt_auh = 0;
        p_mode = 1'b1; p_inc = 1'b1;
        idle(3);
        p_mode = 1'b0; p_inc = 1'b0;
        idle(3);
        check("both_modo", int'(modo), 2);
        check("both_strobes", cnt_aum + cnt_auh, 0);

        // randomized run against the reference model
        for (int k = 0; k < 15000; k++) begin
            if ($urandom_range(299) == 0) p_mode = ~p_mode;
            if ($urandom_range(149) == 0) p_sel  = ~p_sel;
            if ($urandom_range(399) == 0) p_inc  = ~p_inc;
            step($urandom_range(1) == 1, $urandom_range(14) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
